// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_t;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] qnan(input int exp_w, input int frac_w);
        logic [63:0] e_ones;
        e_ones = (64'd1 << exp_w) - 64'd1;
        return (e_ones << frac_w) | (64'd1 << (frac_w - 1));
    endfunction

endpackage

// File: rtl/fp_unpack_class.sv
// Field split and classification of one operand; subnormals are treated as zero.
module fp_unpack_class
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W+FRAC_W:0] op,
    output logic                  sign,
    output logic [EXP_W-1:0]      exp,
    output logic [FRAC_W:0]       sig,
    output logic [1:0]            cls
);

    logic [FRAC_W-1:0] frac;
    fp_class_t         cls_e;

    always_comb begin
        sign  = op[EXP_W+FRAC_W];
        exp   = op[EXP_W+FRAC_W-1:FRAC_W];
        frac  = op[FRAC_W-1:0];
        cls_e = FP_NORM;
        if (exp == '0) begin
            cls_e = FP_ZERO;
        end else if (&exp) begin
            cls_e = (frac == '0) ? FP_INF : FP_NAN;
        end
        sig = (cls_e == FP_NORM) ? {1'b1, frac} : '0;
    end

    assign cls = cls_e;

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754-style multiplier (unpack / multiply / normalise-round-pack).
// Exception flags are built only when FP_MUL_FLAGS_EN is defined; otherwise flags read 0.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXP_W+FRAC_W:0] input_a,
    input  logic [EXP_W+FRAC_W:0] input_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [EXP_W+FRAC_W:0] output_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            flags
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int PROD_W = 2 * FRAC_W + 2;
    localparam int EXPS_W = EXP_W + 2;
    localparam logic [W-1:0]             QNAN    = W'(qnan(EXP_W, FRAC_W));
    localparam logic signed [EXPS_W-1:0] BIAS_S  = EXPS_W'(bias(EXP_W));
    localparam logic signed [EXPS_W-1:0] EXP_MAX = EXPS_W'((1 << EXP_W) - 1);
    localparam logic signed [EXPS_W-1:0] ONE_S   = EXPS_W'(1);
    localparam logic signed [EXPS_W-1:0] ZERO_S  = '0;

    function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    function automatic logic [W-1:0] sat_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

    function automatic logic [W-1:0] flush_zero(input logic sign);
        return {sign, {(W-1){1'b0}}};
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2;

    logic                     sign_a, sign_b;
    logic [EXP_W-1:0]         exp_a, exp_b;
    logic [FRAC_W:0]          sig_a, sig_b;
    logic [1:0]               cls_a, cls_b;
    logic signed [EXPS_W-1:0] exp_s1;

    logic                     sign_p0;
    logic signed [EXPS_W-1:0] exp_p0;
    logic [FRAC_W:0]          sig_a_p0, sig_b_p0;
    logic [1:0]               cls_a_p0, cls_b_p0;

    logic                     sign_p1;
    logic signed [EXPS_W-1:0] exp_p1;
    logic [PROD_W-1:0]        prod_p1;
    logic [1:0]               cls_a_p1, cls_b_p1;

    logic                     norm_shift, g_bit, r_bit, s_bit, up;
    logic [FRAC_W-1:0]        frac_n;
    logic [FRAC_W:0]          frac_r;
    logic signed [EXPS_W-1:0] exp_n, exp_r;
    logic [W-1:0]             z_n;

    assign en        = ~vld_p2 | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    fp_unpack_class #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_a (
        .op(input_a), .sign(sign_a), .exp(exp_a), .sig(sig_a), .cls(cls_a)
    );

    fp_unpack_class #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_b (
        .op(input_b), .sign(sign_b), .exp(exp_b), .sig(sig_b), .cls(cls_b)
    );

    // Wide enough that ea+eb-BIAS never wraps for any pair of fields
    assign exp_s1 = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1 -> 2: unpacked operands
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p0  <= sign_a ^ sign_b;
            exp_p0   <= exp_s1;
            sig_a_p0 <= sig_a;
            sig_b_p0 <= sig_b;
            cls_a_p0 <= cls_a;
            cls_b_p0 <= cls_b;
        end
    end

    // Stage 2 -> 3: raw significand product
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1  <= sign_p0;
            exp_p1   <= exp_p0;
            prod_p1  <= sig_a_p0 * sig_b_p0;
            cls_a_p1 <= cls_a_p0;
            cls_b_p1 <= cls_b_p0;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags_n;
    logic [3:0] flags_p2;
`endif

    always_comb begin
        norm_shift = prod_p1[PROD_W-1];
        if (norm_shift) begin
            frac_n = prod_p1[PROD_W-2 -: FRAC_W];
            g_bit  = prod_p1[PROD_W-2-FRAC_W];
            r_bit  = prod_p1[PROD_W-3-FRAC_W];
            s_bit  = |prod_p1[PROD_W-4-FRAC_W:0];
            exp_n  = exp_p1 + ONE_S;
        end else begin
            frac_n = prod_p1[PROD_W-3 -: FRAC_W];
            g_bit  = prod_p1[PROD_W-3-FRAC_W];
            r_bit  = prod_p1[PROD_W-4-FRAC_W];
            s_bit  = |prod_p1[PROD_W-5-FRAC_W:0];
            exp_n  = exp_p1;
        end
        up     = rne_up(frac_n[0], g_bit, r_bit, s_bit);
        frac_r = {1'b0, frac_n} + {{FRAC_W{1'b0}}, up};
        // A carry out of the fraction leaves it all-zero, so only the exponent moves
        exp_r  = exp_n + (frac_r[FRAC_W] ? ONE_S : ZERO_S);
`ifdef FP_MUL_FLAGS_EN
        flags_n = 4'b0000;
`endif
        if ((cls_a_p1 == FP_NAN) || (cls_b_p1 == FP_NAN) ||
            (cls_a_p1 == FP_INF && cls_b_p1 == FP_ZERO) ||
            (cls_a_p1 == FP_ZERO && cls_b_p1 == FP_INF)) begin
            z_n = QNAN;
`ifdef FP_MUL_FLAGS_EN
            flags_n[FLAG_INVALID] = 1'b1;
`endif
        end else if (cls_a_p1 == FP_INF || cls_b_p1 == FP_INF) begin
            z_n = sat_inf(sign_p1);
        end else if (cls_a_p1 == FP_ZERO || cls_b_p1 == FP_ZERO) begin
            z_n = flush_zero(sign_p1);
        end else if (exp_r >= EXP_MAX) begin
            z_n = sat_inf(sign_p1);
`ifdef FP_MUL_FLAGS_EN
            flags_n[FLAG_OVERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]  = 1'b1;
`endif
        end else if (exp_r <= ZERO_S) begin
            z_n = flush_zero(sign_p1);
`ifdef FP_MUL_FLAGS_EN
            flags_n[FLAG_UNDERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]   = 1'b1;
`endif
        end else begin
            z_n = {sign_p1, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
            flags_n[FLAG_INEXACT] = g_bit | r_bit | s_bit;
`endif
        end
    end

    // Stage 3 -> output: packed result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_z <= '0;
        end else if (en && vld_p1) begin
            output_z <= z_n;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_p2 <= 4'b0000;
        end else if (en && vld_p1) begin
            flags_p2 <= flags_n;
        end
    end
    assign flags = flags_p2;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (EXP_W=8, FRAC_W=23); expected flags follow FP_MUL_FLAGS_EN.
module tb_fp_mul_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        in_valid, in_ready;
    logic [31:0] output_z;
    logic        out_valid, out_ready;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FP_MUL_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic [31:0] sa [6];
    logic [31:0] sb [6];
    logic [31:0] sz [6];

    fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_b(input_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .output_z(output_z), .out_valid(out_valid),
        .out_ready(out_ready), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] xf(input logic [3:0] f);
        return {28'b0, (FL ? f : 4'b0000)};
    endfunction

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] z, input logic [3:0] f);
        @(negedge clk);
        input_a   = a;
        input_b   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("%s_latency", tag), 32'(out_valid), 32'd0);
        @(negedge clk);
        check($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s_z", tag), output_z, z);
        check($sformatf("%s_flags", tag), 32'(flags), xf(f));
    endtask

    initial begin
        int acc;
        int got;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_a   = '0;
        input_b   = '0;

        sa[0] = 32'h40400000; sb[0] = 32'h40200000; sz[0] = 32'h40F00000;
        sa[1] = 32'hBFC00000; sb[1] = 32'h40000000; sz[1] = 32'hC0400000;
        sa[2] = 32'h3F800000; sb[2] = 32'h3F800000; sz[2] = 32'h3F800000;
        sa[3] = 32'h40000000; sb[3] = 32'h40000000; sz[3] = 32'h40800000;
        sa[4] = 32'h3F800001; sb[4] = 32'h3F800001; sz[4] = 32'h3F800002;
        sa[5] = 32'h3FFFFFFF; sb[5] = 32'h3FFFFFFF; sz[5] = 32'h407FFFFE;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_output_z", output_z, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_one("mul_3x2p5",   32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000);
        run_one("mul_neg",     32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
        run_one("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_one("nan_x_one",   32'h7F800123, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_one("inf_x_neg2",  32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
        run_one("zero_x_neg3", 32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000);
        run_one("daz_subnorm", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
        run_one("overflow",    32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        run_one("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_one("rne_inexact", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_one("norm_shift",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);

        // Back-to-back stream with the consumer stalled for five cycles
        acc = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            out_ready = (c >= 8);
            in_valid  = (acc < 6);
            input_a   = sa[(acc < 6) ? acc : 0];
            input_b   = sb[(acc < 6) ? acc : 0];
            #1;
            if (c >= 3 && c <= 7) begin
                check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
                check($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("stall_hold_c%0d", c), output_z, sz[0]);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream_z%0d", got), output_z, sz[got]);
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        check("stream_count", 32'(got), 32'd6);
        check("stream_accepted", 32'(acc), 32'd6);

        // Reset asserted with three operations in flight
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            input_a   = sa[c];
            input_b   = sb[c];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("flush_valid_now", 32'(out_valid), 32'd0);
        check("flush_output_z", output_z, 32'd0);
        check("flush_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("flush_quiet_c%0d", c), 32'(out_valid), 32'd0);
        end

        run_one("after_flush", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
